// File: rtl/w5300_receiver.sv
// W5300 socket-N receive engine: polls RX size, streams FIFO words to a buffer, issues RECV.
// Optional W5300_RX_DROP_OVERSIZE_EN drains packets larger than the local buffer.
module w5300_receiver #(
    parameter logic [2:0] N = 3'd0,
    parameter int ETH_RX_BUFFER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_en,
    output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
    output logic [15:0]                    eth_rx_buffer_data,
    output logic                           eth_rx_buffer_wr,
    output logic [16:0]                    eth_rx_bytes,
    output logic                           rx_done,
    output logic                           rx_overflow,
    output logic [10:0]                    addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state
);

    localparam logic       OP_RD = 1'b0;
    localparam logic       OP_WR = 1'b1;
    localparam logic [9:0] SN_CR = 10'h002;
    localparam logic [9:0] SN_RX_RSR0 = 10'h028;
    localparam logic [9:0] SN_RX_RSR2 = 10'h02a;
    localparam logic [9:0] SN_RX_FIFOR = 10'h030;
    localparam logic [9:0] IDLE_REG = 10'h3fe;
    localparam logic [15:0] SN_CR_RECV = 16'h0040;

    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] r, input logic [2:0] n);
        return 10'h200 + {1'b0, n, 6'h00} + r;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        READ_RX_SIZE,
        CHECK_RX_SIZE,
        READ_PKT_INFO,
        READ_FIFO,
        DO_RECV,
        POST_RECV
    } state_t;

    state_t      state;
    logic        op_cnt;
    logic [16:0] rsr;
    logic [16:0] pkt_bytes;
    logic [16:0] words;
    logic [16:0] word_cnt;
    logic        drop;

    logic [16:0] pkt_in;
    logic [16:0] words_in;

    assign pkt_in = {1'b0, rd_data};
    assign words_in = (pkt_in + {16'h0, pkt_in[0]}) >> 1;

`ifdef W5300_RX_DROP_OVERSIZE_EN
    localparam logic [17:0] BUF_WORDS = 18'(1) << ETH_RX_BUFFER_WIDTH;
    logic oversize;
    assign oversize = {1'b0, words_in} > BUF_WORDS;
`else
    assign drop = 1'b0;
    assign rx_overflow = 1'b0;
`endif

    // Write strobe is tied to the completing FIFO read so data is taken straight off the bus.
    assign eth_rx_buffer_wr = (state == READ_FIFO) && op_state && !drop;
    assign eth_rx_buffer_data = eth_rx_buffer_wr ? rd_data : 16'h0;

    always_comb begin
        addr = {OP_RD, IDLE_REG};
        wr_data = 16'h0;
        unique case (state)
            READ_RX_SIZE:
                addr = {OP_RD, get_socket_n_reg(op_cnt ? SN_RX_RSR2 : SN_RX_RSR0, N)};
            READ_PKT_INFO, READ_FIFO:
                addr = {OP_RD, get_socket_n_reg(SN_RX_FIFOR, N)};
            DO_RECV: begin
                addr = {OP_WR, get_socket_n_reg(SN_CR, N)};
                wr_data = SN_CR_RECV;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_cnt <= 1'b0;
            rsr <= 17'h0;
            pkt_bytes <= 17'h0;
            words <= 17'h0;
            word_cnt <= 17'h0;
            eth_rx_buffer_addr <= '0;
            eth_rx_bytes <= 17'h0;
            rx_done <= 1'b0;
`ifdef W5300_RX_DROP_OVERSIZE_EN
            drop <= 1'b0;
            rx_overflow <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_en) begin
                        state <= READ_RX_SIZE;
                        op_cnt <= 1'b0;
                        eth_rx_buffer_addr <= '0;
                    end
                end
                READ_RX_SIZE: begin
                    if (op_state) begin
                        if (!op_cnt) begin
                            rsr[16] <= rd_data[0];
                            op_cnt <= 1'b1;
                        end else begin
                            rsr[15:0] <= rd_data;
                            op_cnt <= 1'b0;
                            state <= CHECK_RX_SIZE;
                        end
                    end
                end
                CHECK_RX_SIZE: begin
                    op_cnt <= 1'b0;
                    state <= (rsr == 17'h0) ? IDLE : READ_PKT_INFO;
                end
                READ_PKT_INFO: begin
                    if (op_state) begin
                        pkt_bytes <= pkt_in;
                        words <= words_in;
                        word_cnt <= 17'h0;
`ifdef W5300_RX_DROP_OVERSIZE_EN
                        drop <= oversize;
                        if (oversize) rx_overflow <= 1'b1;
`endif
                        state <= (words_in == 17'h0) ? DO_RECV : READ_FIFO;
                    end
                end
                READ_FIFO: begin
                    if (op_state) begin
                        eth_rx_buffer_addr <= eth_rx_buffer_addr + 1'b1;
                        word_cnt <= word_cnt + 17'd1;
                        if (word_cnt + 17'd1 == words) state <= DO_RECV;
                    end
                end
                DO_RECV: begin
                    if (op_state) begin
                        state <= POST_RECV;
                        rx_done <= 1'b1;
                        eth_rx_bytes <= drop ? 17'h0 : pkt_bytes;
                    end
                end
                POST_RECV: begin
                    eth_rx_buffer_addr <= '0;
`ifdef W5300_RX_DROP_OVERSIZE_EN
                    drop <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_receiver.sv
// Directed bench for w5300_receiver with a W5300 register-bus responder.
module tb_w5300_receiver;

    localparam int W = 2;
    localparam logic [10:0] A_RSR0 = 11'h228;
    localparam logic [10:0] A_RSR2 = 11'h22a;
    localparam logic [10:0] A_FIFOR = 11'h230;
    localparam logic [10:0] A_CR = 11'h602;
    localparam logic [10:0] A_IDLE = 11'h3fe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic op_state = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic [W-1:0] eth_rx_buffer_addr;
    logic [15:0] eth_rx_buffer_data;
    logic eth_rx_buffer_wr;
    logic [16:0] eth_rx_bytes;
    logic rx_done;
    logic rx_overflow;
    logic [10:0] addr;
    logic [15:0] wr_data;

    w5300_receiver #(.N(3'd0), .ETH_RX_BUFFER_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en),
        .eth_rx_buffer_addr(eth_rx_buffer_addr),
        .eth_rx_buffer_data(eth_rx_buffer_data),
        .eth_rx_buffer_wr(eth_rx_buffer_wr),
        .eth_rx_bytes(eth_rx_bytes), .rx_done(rx_done),
        .rx_overflow(rx_overflow), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .op_state(op_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int wait_n = 0;
    logic [16:0] rsr_val = 17'h0;
    logic [15:0] fifo_mem [16];
    int fifo_idx = 0;
    int fifo_base = 0;
    int cnt = 0;

    // responder: completes the presented op after wait_n low cycles
    always @(posedge clk) begin
        #1;
        if (!rst_n || addr == A_IDLE) begin
            op_state = 1'b0; rd_data = 16'h0; cnt = 0;
        end else if (cnt >= wait_n) begin
            op_state = 1'b1; cnt = 0;
            case (addr)
                A_RSR0: rd_data = {15'h0, rsr_val[16]};
                A_RSR2: rd_data = rsr_val[15:0];
                A_FIFOR: begin
                    rd_data = fifo_mem[(fifo_idx - fifo_base) % 16];
                    fifo_idx++;
                end
                default: rd_data = 16'h0;
            endcase
        end else begin
            op_state = 1'b0; rd_data = 16'h0; cnt++;
        end
    end

    int rsr0_n = 0, rsr2_n = 0, fifor_n = 0, cr_n = 0, cr_bad = 0;
    int strobe_n = 0, stray_n = 0, done_n = 0, unstable_n = 0;
    logic [16:0] last_bytes = 17'h0;
    logic [W-1:0] s_addr [64];
    logic [15:0] s_data [64];
    logic [10:0] prev_addr = A_IDLE;
    logic [15:0] prev_wd = 16'h0;
    logic prev_op = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (op_state) begin
                case (addr)
                    A_RSR0: rsr0_n++;
                    A_RSR2: rsr2_n++;
                    A_FIFOR: fifor_n++;
                    A_CR: begin
                        cr_n++;
                        if (wr_data !== 16'h0040) cr_bad++;
                    end
                    default: ;
                endcase
            end
            if (eth_rx_buffer_wr) begin
                if (!op_state) stray_n++;
                s_addr[strobe_n % 64] = eth_rx_buffer_addr;
                s_data[strobe_n % 64] = eth_rx_buffer_data;
                strobe_n++;
            end
            if (rx_done) begin
                done_n++;
                last_bytes = eth_rx_bytes;
            end
            if (!prev_op && prev_addr != A_IDLE && (addr != prev_addr || wr_data != prev_wd))
                unstable_n++;
        end
        prev_op = op_state;
        prev_addr = addr;
        prev_wd = wr_data;
    end

    int b_rsr0, b_rsr2, b_fifor, b_cr, b_crbad, b_strobe, b_stray, b_done, b_unst;

    task automatic snap();
        b_rsr0 = rsr0_n; b_rsr2 = rsr2_n; b_fifor = fifor_n; b_cr = cr_n;
        b_crbad = cr_bad; b_strobe = strobe_n; b_stray = stray_n;
        b_done = done_n; b_unst = unstable_n;
    endtask

    task automatic run_pkt(input logic [16:0] rsr, input int waits,
                           input bit drop_early, output bit ok);
        @(negedge clk);
        fifo_base = fifo_idx;
        rsr_val = rsr;
        wait_n = waits;
        snap();
        rx_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (drop_early && strobe_n > b_strobe) rx_en = 1'b0;
            if (done_n > b_done) begin ok = 1'b1; break; end
        end
        rx_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (eth_rx_buffer_addr !== 2'd0) begin bad++; $display("FAIL reset_baddr got=%0h want=0", eth_rx_buffer_addr); end
        total++; if (eth_rx_buffer_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%0b want=0", eth_rx_buffer_wr); end
        total++; if (eth_rx_buffer_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", eth_rx_buffer_data); end
        total++; if (eth_rx_bytes !== 17'h0) begin bad++; $display("FAIL reset_bytes got=%0h want=0", eth_rx_bytes); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", rx_done); end
        total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", rx_overflow); end
        total++; if (addr !== A_IDLE) begin bad++; $display("FAIL reset_addr got=%0h want=%0h", addr, A_IDLE); end
        total++; if (wr_data !== 16'h0) begin bad++; $display("FAIL reset_wrdata got=%0h want=0", wr_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rsr_zero();
        bit ok = 1'b0;
        @(negedge clk);
        rsr_val = 17'h0; wait_n = 0;
        snap();
        rx_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rsr2_n - b_rsr2 >= 2) begin ok = 1'b1; break; end
        end
        rx_en = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL rsr0_poll_timeout got=%0d want=2", rsr2_n - b_rsr2); end
        total++; if (rsr0_n - b_rsr0 !== 2) begin bad++; $display("FAIL rsr0_reads got=%0d want=2", rsr0_n - b_rsr0); end
        total++; if (rsr2_n - b_rsr2 !== 2) begin bad++; $display("FAIL rsr2_reads got=%0d want=2", rsr2_n - b_rsr2); end
        total++; if (fifor_n - b_fifor !== 0) begin bad++; $display("FAIL rsr0_fifor got=%0d want=0", fifor_n - b_fifor); end
        total++; if (done_n - b_done !== 0) begin bad++; $display("FAIL rsr0_done got=%0d want=0", done_n - b_done); end
    endtask

    task automatic check_pkt(input string nm, input bit ok, input int nw,
                             input logic [16:0] bytes, input int nfifo);
        total++; if (!ok) begin bad++; $display("FAIL %s_timeout got=0 want=1", nm); end
        total++; if (strobe_n - b_strobe !== nw) begin bad++; $display("FAIL %s_strobes got=%0d want=%0d", nm, strobe_n - b_strobe, nw); end
        total++; if (fifor_n - b_fifor !== nfifo) begin bad++; $display("FAIL %s_fifor got=%0d want=%0d", nm, fifor_n - b_fifor, nfifo); end
        total++; if (cr_n - b_cr !== 1) begin bad++; $display("FAIL %s_recv got=%0d want=1", nm, cr_n - b_cr); end
        total++; if (cr_bad - b_crbad !== 0) begin bad++; $display("FAIL %s_recv_data got=%0d want=0", nm, cr_bad - b_crbad); end
        total++; if (done_n - b_done !== 1) begin bad++; $display("FAIL %s_done got=%0d want=1", nm, done_n - b_done); end
        total++; if (last_bytes !== bytes) begin bad++; $display("FAIL %s_bytes got=%0d want=%0d", nm, last_bytes, bytes); end
        total++; if (stray_n - b_stray !== 0) begin bad++; $display("FAIL %s_stray got=%0d want=0", nm, stray_n - b_stray); end
    endtask

    task automatic check_words(input string nm, input int nw);
        for (int k = 0; k < nw; k++) begin
            total++;
            if (s_addr[(b_strobe + k) % 64] !== W'(k) || s_data[(b_strobe + k) % 64] !== fifo_mem[k + 1]) begin
                bad++;
                $display("FAIL %s_word%0d got=%0h@%0d want=%0h@%0d", nm, k,
                         s_data[(b_strobe + k) % 64], s_addr[(b_strobe + k) % 64], fifo_mem[k + 1], k);
            end
        end
    endtask

    task automatic load8();
        fifo_mem[0] = 16'd8;
        fifo_mem[1] = 16'h1111; fifo_mem[2] = 16'h2222;
        fifo_mem[3] = 16'h3333; fifo_mem[4] = 16'h4444;
    endtask

    task automatic test_pkt8();
        bit ok;
        load8();
        run_pkt(17'd10, 0, 1'b0, ok);
        check_pkt("pkt8", ok, 4, 17'd8, 5);
        check_words("pkt8", 4);
    endtask

    task automatic test_pkt_odd();
        bit ok;
        fifo_mem[0] = 16'd5;
        fifo_mem[1] = 16'h0102; fifo_mem[2] = 16'h0304; fifo_mem[3] = 16'h0500;
        run_pkt(17'd7, 0, 1'b0, ok);
        check_pkt("pkt5", ok, 3, 17'd5, 4);
        check_words("pkt5", 3);
    endtask

    task automatic test_wait_states();
        bit ok;
        load8();
        run_pkt(17'd10, 7, 1'b1, ok);
        check_pkt("wait", ok, 4, 17'd8, 5);
        check_words("wait", 4);
        total++; if (unstable_n - b_unst !== 0) begin bad++; $display("FAIL wait_addr_stable got=%0d want=0", unstable_n - b_unst); end
        wait_n = 0;
    endtask

    task automatic test_pkt_zero();
        bit ok;
        fifo_mem[0] = 16'd0;
        run_pkt(17'd2, 0, 1'b0, ok);
        check_pkt("pkt0", ok, 0, 17'd0, 1);
    endtask

    task automatic test_wrap();
        bit ok;
        fifo_mem[0] = 16'd12;
        for (int k = 1; k <= 6; k++) fifo_mem[k] = 16'hA000 + 16'(k);
        run_pkt(17'd14, 0, 1'b0, ok);
`ifdef W5300_RX_DROP_OVERSIZE_EN
        check_pkt("drop", ok, 0, 17'd0, 7);
        total++; if (rx_overflow !== 1'b1) begin bad++; $display("FAIL drop_ovf got=%0b want=1", rx_overflow); end
`else
        check_pkt("wrap", ok, 6, 17'd12, 7);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (s_addr[(b_strobe + k) % 64] !== W'(k % 4) || s_data[(b_strobe + k) % 64] !== fifo_mem[k + 1]) begin
                bad++;
                $display("FAIL wrap_word%0d got=%0h@%0d want=%0h@%0d", k,
                         s_data[(b_strobe + k) % 64], s_addr[(b_strobe + k) % 64], fifo_mem[k + 1], k % 4);
            end
        end
        total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%0b want=0", rx_overflow); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        @(negedge clk);
        fifo_base = fifo_idx;
        fifo_mem[0] = 16'd10;
        for (int k = 1; k <= 5; k++) fifo_mem[k] = 16'hB000 + 16'(k);
        rsr_val = 17'd12; wait_n = 0;
        snap();
        rx_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (strobe_n - b_strobe >= 3) begin ok = 1'b1; break; end
        end
        @(posedge clk); #3;
        rst_n = 1'b0; rx_en = 1'b0;
        @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL mid_reach3 got=%0d want=3", strobe_n - b_strobe); end
        total++; if (eth_rx_buffer_wr !== 1'b0 || eth_rx_buffer_addr !== 2'd0 || eth_rx_buffer_data !== 16'h0) begin
            bad++; $display("FAIL mid_buf got=%0b/%0h/%0h want=0/0/0", eth_rx_buffer_wr, eth_rx_buffer_addr, eth_rx_buffer_data);
        end
        total++; if (eth_rx_bytes !== 17'h0 || rx_done !== 1'b0 || rx_overflow !== 1'b0) begin
            bad++; $display("FAIL mid_status got=%0h/%0b/%0b want=0/0/0", eth_rx_bytes, rx_done, rx_overflow);
        end
        total++; if (addr !== A_IDLE || wr_data !== 16'h0) begin bad++; $display("FAIL mid_addr got=%0h/%0h want=%0h/0", addr, wr_data, A_IDLE); end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (cr_n - b_cr !== 0) begin bad++; $display("FAIL mid_no_recv got=%0d want=0", cr_n - b_cr); end
        total++; if (strobe_n - b_strobe !== 3) begin bad++; $display("FAIL mid_strobes got=%0d want=3", strobe_n - b_strobe); end
        total++; if (done_n - b_done !== 0) begin bad++; $display("FAIL mid_done got=%0d want=0", done_n - b_done); end
    endtask

    initial begin
        test_reset();
        test_rsr_zero();
        test_pkt8();
        test_pkt_odd();
        test_wait_states();
        test_pkt_zero();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
